rr_mux_reg: RTL and testbench

Parametrised N-channel, W-bit arbitrating multiplexer with a valid/ready handshake on every input and one output register stage. It generalises the fixed-width combinational 2:1/4:1 mux family to any width and channel count and adds arbitration, either round-robin or fixed priority, plus backpressure. It merges several pipeline request streams (for example fetch/load/store requesters) onto one downstream port, one transfer per cycle.

---
 rtl/rr_mux_reg_if.sv | 26 ++
 rtl/rr_mux_reg.sv | 105 ++++++++++
 tb/tb_rr_mux_reg.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_mux_reg_if.sv
// Handshake bundle between N request sources and the arbitrating mux, plus its registered output port.
// The slave modport is the mux side; the master modport is the sources/sink side.
interface rr_mux_reg_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [CHW-1:0]       out_ch;
    logic                 out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/rr_mux_reg.sv
// N-channel arbitrating mux (round-robin or fixed priority) into one output register; 1-cycle latency.
// Backpressure: the register reloads only when empty or drained this cycle; in_ready is 0 while stalled.
module rr_mux_reg #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter bit RR    = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_mux_reg_if.slave  bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef struct packed {
        logic             vld;
        logic [CHW-1:0]   ch;
        logic [WIDTH-1:0] dat;
    } out_t;

    out_t           out_q, out_d;
    logic [CHW-1:0] ptr_q, ptr_d;

    logic           load;
    logic           gnt_vld;
    logic [CHW-1:0] gnt_idx;
    logic [CHW-1:0] gnt_nxt;
    logic [CHW-1:0] base;
    logic [WIDTH-1:0] gnt_dat;

    assign load = !out_q.vld || bus.out_ready;
    assign base = RR ? ptr_q : '0;

    // Search base, base+1, ... wrapping at NCH so non-power-of-2 counts never index past the last channel.
    always_comb begin : arb
        logic [CHW:0] sum;
        sum     = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            sum = {1'b0, base} + (CHW+1)'(k);
            if (sum >= (CHW+1)'(NCH)) begin
                sum = sum - (CHW+1)'(NCH);
            end
            if (!gnt_vld && bus.in_valid[sum[CHW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = sum[CHW-1:0];
            end
        end
    end

    always_comb begin
        gnt_dat = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt_idx == CHW'(i)) begin
                gnt_dat = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign gnt_nxt = (gnt_idx == CHW'(NCH-1)) ? '0 : gnt_idx + CHW'(1);

    // rst_n gates the accept so no source sees a handshake while the block is held in reset.
    always_comb begin
        bus.in_ready = '0;
        if (rst_n && load && gnt_vld) begin
            bus.in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        out_d = out_q;
        ptr_d = ptr_q;
        if (load) begin
            if (gnt_vld) begin
                out_d.vld = 1'b1;
                out_d.ch  = gnt_idx;
                out_d.dat = gnt_dat;
                if (RR) begin
                    ptr_d = gnt_nxt;
                end
            end else begin
                out_d.vld = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            ptr_q <= '0;
        end else begin
            out_q <= out_d;
            ptr_q <= ptr_d;
        end
    end

    assign bus.out_valid = out_q.vld;
    assign bus.out_data  = out_q.dat;
    assign bus.out_ch    = out_q.ch;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.in_ready));
    a_ptr_range:    assert property (@(posedge clk) disable iff (!rst_n) {1'b0, ptr_q} < (CHW+1)'(NCH));
    a_stall_hold:   assert property (@(posedge clk) disable iff (!rst_n)
                                     (out_q.vld && !bus.out_ready) |=> $stable(out_q));
endmodule

// File: tb/tb_rr_mux_reg.sv
// Bench for rr_mux_reg: three instances (4-ch round-robin, 3-ch round-robin, 4-ch fixed priority).
// Accepted transfers are queued at drive time and checked when the sink consumes them.
module tb_rr_mux_reg;
    logic clk;
    logic rst_n;

    rr_mux_reg_if #(.WIDTH(32), .NCH(4)) b4 ();
    rr_mux_reg_if #(.WIDTH(8),  .NCH(3)) b3 ();
    rr_mux_reg_if #(.WIDTH(32), .NCH(4)) bp ();

    rr_mux_reg #(.WIDTH(32), .NCH(4), .RR(1'b1)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    rr_mux_reg #(.WIDTH(8),  .NCH(3), .RR(1'b1)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
    rr_mux_reg #(.WIDTH(32), .NCH(4), .RR(1'b0)) up (.clk(clk), .rst_n(rst_n), .bus(bp.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [31:0] dat;
    } sb_t;

    typedef struct {
        logic [3:0] vld;
        logic       rdy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
    } vec_t;

    sb_t  sb4[$];
    sb_t  sb3[$];
    sb_t  sbp[$];
    vec_t tv[15];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv4(input logic [3:0] vld, input logic rdy, input logic [3:0] exp);
        int ci;
        b4.in_valid  = vld;
        b4.out_ready = rdy;
        #1;
        chk("u4 in_ready", b4.in_ready, exp);
        if (exp != 4'b0000) begin
            ci = oh_idx({4'b0, exp});
            sb4.push_back('{ch: ci, dat: b4.in_data[ci*32 +: 32]});
        end
    endtask

    task automatic drv3(input logic [2:0] vld, input logic rdy, input logic [2:0] exp);
        int ci;
        b3.in_valid  = vld;
        b3.out_ready = rdy;
        #1;
        chk("u3 in_ready", b3.in_ready, exp);
        if (exp != 3'b000) begin
            ci = oh_idx({5'b0, exp});
            sb3.push_back('{ch: ci, dat: 32'(b3.in_data[ci*8 +: 8])});
        end
    endtask

    task automatic drvp(input logic [3:0] vld, input logic rdy, input logic [3:0] exp);
        int ci;
        bp.in_valid  = vld;
        bp.out_ready = rdy;
        #1;
        chk("up in_ready", bp.in_ready, exp);
        if (exp != 4'b0000) begin
            ci = oh_idx({4'b0, exp});
            sbp.push_back('{ch: ci, dat: bp.in_data[ci*32 +: 32]});
        end
    endtask

    // Sink side: an entry is consumed on the edge following a negedge where valid and ready are both high.
    always @(negedge clk) begin
        sb_t e;
        if (rst_n && b4.out_valid && b4.out_ready) begin
            if (sb4.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL u4 sb: output ch %0d with nothing expected", b4.out_ch);
            end else begin
                e = sb4.pop_front();
                chk("u4 out_ch", 64'(b4.out_ch), 64'(e.ch));
                chk("u4 out_data", 64'(b4.out_data), 64'(e.dat));
            end
        end
    end

    always @(negedge clk) begin
        sb_t e;
        if (rst_n && b3.out_valid && b3.out_ready) begin
            if (sb3.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL u3 sb: output ch %0d with nothing expected", b3.out_ch);
            end else begin
                e = sb3.pop_front();
                chk("u3 out_ch", 64'(b3.out_ch), 64'(e.ch));
                chk("u3 out_data", 64'(b3.out_data), 64'(e.dat));
            end
        end
    end

    always @(negedge clk) begin
        sb_t e;
        if (rst_n && bp.out_valid && bp.out_ready) begin
            if (sbp.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL up sb: output ch %0d with nothing expected", bp.out_ch);
            end else begin
                e = sbp.pop_front();
                chk("up out_ch", 64'(bp.out_ch), 64'(e.ch));
                chk("up out_data", 64'(bp.out_data), 64'(e.dat));
            end
        end
    end

    initial begin
        // vld, out_ready, expected in_ready, expected out_valid after the edge
        tv = '{
            '{4'b1111, 1'b1, 4'b0001, 1'b1},
            '{4'b1111, 1'b1, 4'b0010, 1'b1},
            '{4'b1111, 1'b1, 4'b0100, 1'b1},
            '{4'b1111, 1'b1, 4'b1000, 1'b1},
            '{4'b1111, 1'b1, 4'b0001, 1'b1},
            '{4'b1111, 1'b1, 4'b0010, 1'b1},
            '{4'b1001, 1'b1, 4'b1000, 1'b1},
            '{4'b0110, 1'b0, 4'b0000, 1'b1},
            '{4'b0110, 1'b1, 4'b0010, 1'b1},
            '{4'b0000, 1'b1, 4'b0000, 1'b0},
            '{4'b0000, 1'b0, 4'b0000, 1'b0},
            '{4'b0011, 1'b0, 4'b0001, 1'b1},
            '{4'b0011, 1'b0, 4'b0000, 1'b1},
            '{4'b0011, 1'b1, 4'b0010, 1'b1},
            '{4'b0000, 1'b1, 4'b0000, 1'b0}
        };

        rst_n = 1'b0;
        b4.in_valid = 4'b1111; b4.out_ready = 1'b1;
        b4.in_data  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        b3.in_valid = 3'b000;  b3.out_ready = 1'b1;
        b3.in_data  = {8'hC3, 8'hB2, 8'hA1};
        bp.in_valid = 4'b0000; bp.out_ready = 1'b1;
        bp.in_data  = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};

        #3;
        chk("reset out_valid", b4.out_valid, 1'b0);
        chk("reset out_data", b4.out_data, 32'h0);
        chk("reset out_ch", b4.out_ch, 2'd0);
        chk("reset in_ready", b4.in_ready, 4'b0000);
        b4.in_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            tick();
            if (i > 0) chk("tbl out_valid", b4.out_valid, tv[i-1].exp_ov);
            drv4(tv[i].vld, tv[i].rdy, tv[i].exp_rdy);
        end
        tick();
        chk("tbl out_valid", b4.out_valid, tv[14].exp_ov);

        // Backpressure: hold an A5 entry for 3 cycles, then refill from ptr=3 with no bubble.
        b4.in_data[2*32 +: 32] = 32'hA5A5A5A5;
        drv4(4'b0100, 1'b0, 4'b0100);
        tick();
        b4.in_data[2*32 +: 32] = 32'h33333333;
        for (int k = 0; k < 3; k++) begin
            drv4(4'b1111, 1'b0, 4'b0000);
            tick();
            chk("stall out_valid", b4.out_valid, 1'b1);
            chk("stall out_data", b4.out_data, 32'hA5A5A5A5);
        end
        drv4(4'b1111, 1'b1, 4'b1000);
        tick();
        chk("refill out_ch", b4.out_ch, 2'd3);
        chk("refill out_valid", b4.out_valid, 1'b1);

        // Idle drain: valid falls after one cycle, data and ch hold.
        drv4(4'b0000, 1'b1, 4'b0000);
        tick();
        chk("drain out_valid", b4.out_valid, 1'b0);
        chk("drain out_data", b4.out_data, 32'h44444444);
        chk("drain out_ch", b4.out_ch, 2'd3);

        // Mid-cycle reset with a held entry and ptr=1.
        drv4(4'b0001, 1'b0, 4'b0001);
        tick();
        chk("pre-reset out_valid", b4.out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", b4.out_valid, 1'b0);
        chk("async reset out_data", b4.out_data, 32'h0);
        chk("async reset out_ch", b4.out_ch, 2'd0);
        chk("async reset in_ready", b4.in_ready, 4'b0000);
        sb4.delete();
        b4.in_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drv4(4'b1111, 1'b1, 4'b0001);
        tick();
        chk("post-reset out_ch", b4.out_ch, 2'd0);
        drv4(4'b0000, 1'b1, 4'b0000);
        tick();

        // Three channels: ptr wraps 2 -> 0 and never reaches 3.
        drv3(3'b010, 1'b1, 3'b010);
        tick(); drv3(3'b010, 1'b1, 3'b010);
        tick(); drv3(3'b101, 1'b1, 3'b100);
        tick(); drv3(3'b001, 1'b1, 3'b001);
        tick(); drv3(3'b111, 1'b1, 3'b010);
        tick(); drv3(3'b101, 1'b1, 3'b100);
        tick(); drv3(3'b001, 1'b1, 3'b001);
        tick(); drv3(3'b000, 1'b1, 3'b000);
        tick();
        chk("u3 idle out_valid", b3.out_valid, 1'b0);
        chk("u3 idle out_data", b3.out_data, 8'hA1);

        // Fixed priority: ch0 wins while valid, ch2 only once ch0 drops.
        for (int k = 0; k < 4; k++) begin
            drvp(4'b0101, 1'b1, 4'b0001);
            tick();
            chk("up prio out_ch", bp.out_ch, 2'd0);
        end
        drvp(4'b0100, 1'b1, 4'b0100);
        tick();
        chk("up ch2 out_ch", bp.out_ch, 2'd2);
        drvp(4'b1111, 1'b1, 4'b0001);
        tick();
        chk("up no-rotate out_ch", bp.out_ch, 2'd0);
        drvp(4'b0000, 1'b1, 4'b0000);
        tick();
        tick();

        chk("u4 sb empty", 64'(sb4.size()), 64'd0);
        chk("u3 sb empty", 64'(sb3.size()), 64'd0);
        chk("up sb empty", 64'(sbp.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
